div_gen: RTL and testbench

DIV_GEN -- requirements
Module: div_gen

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 18 +
 rtl/div_gen.sv | 154 +++++++++++++++
 tb/tb_div_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: state encoding, default width
// and the field layout of the packed {remainder, quotient} result.
package div_pkg;

    localparam int DIV_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } div_state_e;

    // Field index within result_o; each field is DATA_W bits wide.
    localparam int QUOT_FIELD = 0;
    localparam int REM_FIELD  = 1;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: given the shifted partial remainder and the
// divisor, produce the next partial remainder and one quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic [DATA_W:0]   part_rem,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] next_rem,
    output logic              q_bit
);

    // A successful subtract always leaves a value below the divisor, so it fits DATA_W bits.
    assign q_bit    = (part_rem >= {1'b0, divisor});
    assign next_rem = q_bit ? DATA_W'(part_rem - {1'b0, divisor}) : part_rem[DATA_W-1:0];

endmodule

// File: rtl/div_gen.sv
// Multi-cycle restoring divider (signed/unsigned) with abort and divide-by-zero path.
// Optional macro DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module div_gen
    import div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                busy_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? (~v + DATA_W'(1)) : v;
    endfunction

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   dvd_q, dvd_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic                neg_quot_q, neg_quot_d;
    logic                neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0] result_d;
    logic                ready_d;

    logic                op1_neg, op2_neg;
    logic [DATA_W-1:0]   op1_mag, op2_mag;
    logic [DATA_W-1:0]   step_rem;
    logic                step_q;
    logic [DATA_W-1:0]   quot_fin, rem_fin;

    assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
    assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
    assign op1_mag = neg_if(opdata1_i, op1_neg);
    assign op2_mag = neg_if(opdata2_i, op2_neg);

    // dvd_q doubles as the quotient: dividend bits shift out as quotient bits shift in.
    div_step #(.DATA_W(DATA_W)) u_step (
        .part_rem ({rem_q, dvd_q[DATA_W-1]}),
        .divisor  (dvs_q),
        .next_rem (step_rem),
        .q_bit    (step_q)
    );

    assign quot_fin = neg_if(dvd_q, neg_quot_q);
    assign rem_fin  = neg_if(rem_q, neg_rem_q);
    assign busy_o   = (state_q != ST_FREE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        ready_d    = 1'b0;
        result_d   = '0;
        case (state_q)
            ST_FREE: begin
                if (start_i && !annul_i) begin
                    cnt_d      = '0;
                    dvd_d      = op1_mag;
                    rem_d      = '0;
                    dvs_d      = op2_mag;
                    neg_quot_d = op1_neg ^ op2_neg;
                    neg_rem_d  = op1_neg;
                    if (opdata2_i == '0) begin
                        state_d = ST_BYZERO;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (op1_mag < op2_mag) begin
                        // Quotient is zero and the remainder is the dividend itself.
                        state_d = ST_END;
                        dvd_d   = '0;
                        rem_d   = op1_mag;
                    end
`endif
                    else begin
                        state_d = ST_ON;
                    end
                end
            end
            ST_BYZERO: begin
                if (annul_i) begin
                    state_d = ST_FREE;
                end else begin
                    state_d    = ST_END;
                    dvd_d      = '0;
                    rem_d      = '0;
                    neg_quot_d = 1'b0;
                    neg_rem_d  = 1'b0;
                end
            end
            ST_ON: begin
                if (annul_i) begin
                    state_d = ST_FREE;
                end else begin
                    dvd_d = {dvd_q[DATA_W-2:0], step_q};
                    rem_d = step_rem;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = ST_END;
                    end
                end
            end
            ST_END: begin
                if (annul_i || !start_i) begin
                    state_d = ST_FREE;
                end else begin
                    ready_d = 1'b1;
                    result_d[QUOT_FIELD*DATA_W +: DATA_W] = quot_fin;
                    result_d[REM_FIELD*DATA_W  +: DATA_W] = rem_fin;
                end
            end
            default: state_d = ST_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FREE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            ready_o    <= 1'b0;
            result_o   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            ready_o    <= ready_d;
            result_o   <= result_d;
        end
    end

endmodule

// File: tb/tb_div_gen.sv
// Randomized scoreboard bench for div_gen (DATA_W=32), with directed abort and reset cases.
module tb_div_gen;

    localparam int DATA_W = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                signed_div_i;
    logic [DATA_W-1:0]   opdata1_i, opdata2_i;
    logic                start_i, annul_i;
    logic [2*DATA_W-1:0] result_o;
    logic                ready_o, busy_o;

    div_gen #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*DATA_W-1:0] res;
        int                  lat;
        int                  start_edge;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   edge_cnt = 0;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input logic [2*DATA_W-1:0] act, input logic [2*DATA_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    // Reference: plain integer division, truncating toward zero.
    function automatic exp_t model(input bit sg, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        exp_t   e;
        longint sa, sb, ma, mb;
        logic [DATA_W-1:0] q, r;
        e.start_edge = 0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        if (b == '0) begin
            e.res = '0;
            e.lat = 2;
            return e;
        end
        q = DATA_W'(sa / sb);
        r = DATA_W'(sa % sb);
        e.res = {r, q};
        e.lat = DATA_W + 1;
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) e.lat = 1;
`else
        if (ma < mb) e.lat = DATA_W + 1;
`endif
        return e;
    endfunction

    // Monitor: pops the scoreboard on each rising ready_o, checks value, latency and hold.
    exp_t cur;
    bit   rdy_prev = 1'b0;
    always @(negedge clk) begin
        if (ready_o && !rdy_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: ready_o=1 result=%h with nothing outstanding", result_o);
            end else begin
                cur = exp_q.pop_front();
                check("result", result_o, cur.res);
                check("latency", 64'(edge_cnt - cur.start_edge), 64'(cur.lat));
            end
        end else if (ready_o && rdy_prev) begin
            check("result_hold", result_o, cur.res);
        end else if (!ready_o && rdy_prev) begin
            check("result_cleared", result_o, '0);
        end
        rdy_prev = ready_o;
    end

    task automatic run_div(input bit sg, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input int hold);
        exp_t e;
        bit   got;
        @(posedge clk); #1;
        signed_div_i = sg;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        e = model(sg, a, b);
        e.start_edge = edge_cnt + 1;
        exp_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 3 * DATA_W; i++) begin
            @(posedge clk); #1;
            // Operand changes while busy must not disturb the result.
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = ~sg;
            if (ready_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready_o=0 after %0d cycles, expected 1", 3 * DATA_W);
            void'(exp_q.pop_front());
        end
        repeat (hold) @(posedge clk);
        #1 start_i = 1'b0;
        @(posedge clk); #1;
        check("ready_drop", 64'(ready_o), 64'd0);
        check("busy_drop", 64'(busy_o), 64'd0);
    endtask

    // Starts a division whose result is never consumed (aborted by annul or reset).
    task automatic start_only(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        @(posedge clk); #1;
        signed_div_i = 1'b0;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
    endtask

    initial begin
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_result", result_o, '0);
        rst = 1'b0;

        run_div(1'b0, 32'd33, 32'd4, 3);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        run_div(1'b0, 32'd5, 32'd0, 2);
        run_div(1'b1, 32'hFFFF_FF00, 32'd0, 0);
        run_div(1'b0, 32'd3, 32'd10, 1);
        run_div(1'b1, 32'hFFFF_FFFD, 32'd10, 0);
        run_div(1'b0, 32'd10, 32'd10, 0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 0);
        run_div(1'b1, 32'd100, 32'hFFFF_FFF9, 0);

        // Abort in ON: annul sampled at edge 11 of the division.
        start_only(32'd12345, 32'd11);
        repeat (10) @(posedge clk);
        #1;
        check("annul_busy_before", 64'(busy_o), 64'd1);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk); #1;
        annul_i = 1'b0;
        check("annul_busy_after", 64'(busy_o), 64'd0);
        check("annul_ready", 64'(ready_o), 64'd0);
        run_div(1'b0, 32'd100, 32'd7, 0);

        // Reset in ON: rst sampled at edge 21 of the division.
        start_only(32'd999, 32'd5);
        repeat (20) @(posedge clk);
        #1;
        rst     = 1'b1;
        annul_i = 1'b1;
        @(posedge clk); #1;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_result", result_o, '0);
        rst     = 1'b0;
        annul_i = 1'b0;
        start_i = 1'b0;
        run_div(1'b1, 32'hFFFF_FC18, 32'd37, 1);

        for (int n = 0; n < 40; n++) begin
            logic [DATA_W-1:0] a, b;
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = $urandom_range(1, 20);
                2:       b = '0;
                default: begin
                    a = $urandom_range(0, 50);
                    b = $urandom_range(51, 1000);
                end
            endcase
            run_div(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 3));
        end

        @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
